// File: rtl/timer_frame_tx.sv
// Serial command-frame transmitter for the timer receiver: sends sync + 4-bit delay
// MSB-first, waits for done, returns a one-cycle ack, aborts on timeout.
module timer_frame_tx #(
    parameter logic [3:0] SYNC_PATTERN = 4'b1101,
    parameter int         TIMEOUT      = 17000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] delay,
    input  logic       done,
    output logic       data,
    output logic       busy,
    output logic       ack,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_DLY       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4
    } state_t;

    // Abort fires on the edge at which the counter would reach TIMEOUT.
    localparam logic [17:0] CNT_LAST = 18'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  bit_q, bit_d;
    logic [1:0]  bit_nxt;
    logic [17:0] cnt_q, cnt_d;
    logic [3:0]  delay_q, delay_d;
    logic        data_q, data_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        tmo_q, tmo_d;

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        data_d  = 1'b0;
        busy_d  = 1'b0;
        ack_d   = 1'b0;
        tmo_d   = 1'b0;
        bit_nxt = bit_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                bit_d = 2'd0;
                if (start) begin
                    state_d = ST_SYNC;
                    delay_d = delay;
                    data_d  = SYNC_PATTERN[3];
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                busy_d = 1'b1;
                if (bit_q == 2'd3) begin
                    state_d = ST_DLY;
                    bit_d   = 2'd0;
                    data_d  = delay_q[3];
                end else begin
                    bit_d  = bit_nxt;
                    data_d = SYNC_PATTERN[~bit_nxt];
                end
            end
            ST_DLY: begin
                busy_d = 1'b1;
                if (bit_q == 2'd3) begin
                    state_d = ST_WAIT_DONE;
                    bit_d   = 2'd0;
                    cnt_d   = 18'd0;
                end else begin
                    bit_d  = bit_nxt;
                    data_d = delay_q[~bit_nxt];
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + 18'd1;
                // done takes priority over a simultaneous timeout
                if (done) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bit_q   <= 2'd0;
            cnt_q   <= 18'd0;
            delay_q <= 4'd0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
        end
    end

    assign data        = data_q;
    assign busy        = busy_q;
    assign ack         = ack_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_timer_frame_tx.sv
// Directed self-checking bench for timer_frame_tx (TIMEOUT reduced to 20).
module tb_timer_frame_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] delay;
    logic       done;
    logic       data;
    logic       busy;
    logic       ack;
    logic       timeout_err;

    int vec_count = 0;
    int err_count = 0;

    timer_frame_tx #(
        .SYNC_PATTERN(4'b1101),
        .TIMEOUT     (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .delay      (delay),
        .done       (done),
        .data       (data),
        .busy       (busy),
        .ack        (ack),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; afterwards delay is scrambled to prove it was latched.
    task automatic start_frame(input logic [3:0] d);
        start = 1'b1;
        delay = d;
        tick();
        start = 1'b0;
        delay = ~d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vec_count++;
        if ({data, busy, ack, timeout_err} !== 4'b0000) begin
            err_count++;
            $display("FAIL reset_outputs: got %b expected 0000", {data, busy, ack, timeout_err});
        end
    endtask

    // Plan items 1 and 2: frame 0101, then done raised 10 cycles into WAIT_DONE.
    task automatic test_frame_and_ack();
        logic [7:0] exp = 8'b1101_0101;
        start_frame(4'b0101);
        for (int i = 0; i < 8; i++) begin
            vec_count++;
            if (data !== exp[7-i] || busy !== 1'b1) begin
                err_count++;
                $display("FAIL frame_bit%0d: data=%b busy=%b expected data=%b busy=1", i, data, busy, exp[7-i]);
            end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            vec_count++;
            if (data !== 1'b0 || busy !== 1'b1 || ack !== 1'b0) begin
                err_count++;
                $display("FAIL wait_done%0d: data=%b busy=%b ack=%b expected 0 1 0", c, data, busy, ack);
            end
            tick();
        end
        done = 1'b1;
        tick();
        vec_count++;
        if (ack !== 1'b1 || busy !== 1'b1 || data !== 1'b0) begin
            err_count++;
            $display("FAIL ack_cycle: ack=%b busy=%b data=%b expected 1 1 0", ack, busy, data);
        end
        tick();
        vec_count++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            err_count++;
            $display("FAIL after_ack: ack=%b busy=%b expected 0 0", ack, busy);
        end
        tick();
        vec_count++;
        if (ack !== 1'b0 || busy !== 1'b0 || data !== 1'b0) begin
            err_count++;
            $display("FAIL idle_done_high: ack=%b busy=%b data=%b expected 0 0 0", ack, busy, data);
        end
        done = 1'b0;
    endtask

    // Plan item 3: a start during the frame is ignored.
    task automatic test_start_ignored();
        logic [7:0] exp = 8'b1101_0101;
        start_frame(4'b0101);
        for (int i = 0; i < 8; i++) begin
            vec_count++;
            if (data !== exp[7-i] || busy !== 1'b1) begin
                err_count++;
                $display("FAIL ignore_bit%0d: data=%b busy=%b expected data=%b busy=1", i, data, busy, exp[7-i]);
            end
            if (i == 3) begin
                start = 1'b1;
                delay = 4'b1111;
                tick();
                start = 1'b0;
            end else begin
                tick();
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            vec_count++;
            if (busy !== 1'b0 || data !== 1'b0) begin
                err_count++;
                $display("FAIL no_second_frame%0d: busy=%b data=%b expected 0 0", c, busy, data);
            end
            tick();
        end
    endtask

    // Plan item 4: timeout, then back-to-back frame with 1000.
    task automatic test_timeout_back_to_back();
        logic [7:0] exp = 8'b1101_0101;
        logic [7:0] exp2 = 8'b1101_1000;
        start_frame(4'b0101);
        for (int i = 0; i < 8; i++) tick();
        for (int c = 0; c < 20; c++) begin
            vec_count++;
            if (timeout_err !== 1'b0 || ack !== 1'b0 || busy !== 1'b1) begin
                err_count++;
                $display("FAIL pre_timeout%0d: tmo=%b ack=%b busy=%b expected 0 0 1", c, timeout_err, ack, busy);
            end
            tick();
        end
        vec_count++;
        if (timeout_err !== 1'b1 || ack !== 1'b0 || busy !== 1'b0) begin
            err_count++;
            $display("FAIL timeout_pulse: tmo=%b ack=%b busy=%b expected 1 0 0", timeout_err, ack, busy);
        end
        start_frame(4'b1000);
        vec_count++;
        if (timeout_err !== 1'b0) begin
            err_count++;
            $display("FAIL timeout_one_cycle: tmo=%b expected 0", timeout_err);
        end
        for (int i = 0; i < 8; i++) begin
            vec_count++;
            if (data !== exp2[7-i] || busy !== 1'b1) begin
                err_count++;
                $display("FAIL b2b_bit%0d: data=%b busy=%b expected data=%b busy=1", i, data, busy, exp2[7-i]);
            end
            tick();
        end
        vec_count++;
        if (data !== exp[0] - 1'b1 && data !== 1'b0) begin
            err_count++;
            $display("FAIL b2b_tail: data=%b expected 0", data);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    // Boundary: done arrives on the last WAIT_DONE cycle; done must win over timeout.
    task automatic test_done_at_timeout();
        start_frame(4'b0011);
        for (int i = 0; i < 8; i++) tick();
        for (int c = 0; c < 19; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        vec_count++;
        if (ack !== 1'b1 || timeout_err !== 1'b0) begin
            err_count++;
            $display("FAIL done_vs_timeout: ack=%b tmo=%b expected 1 0", ack, timeout_err);
        end
        tick();
        vec_count++;
        if (ack !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            err_count++;
            $display("FAIL done_vs_timeout_after: ack=%b tmo=%b busy=%b expected 0 0 0", ack, timeout_err, busy);
        end
    endtask

    // Plan item 5: reset in DLY bit 1, then a clean frame.
    task automatic test_reset_mid_frame();
        logic [7:0] exp = 8'b1101_1110;
        start_frame(4'b0011);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vec_count++;
        if ({data, busy, ack, timeout_err} !== 4'b0000) begin
            err_count++;
            $display("FAIL mid_reset: got %b expected 0000", {data, busy, ack, timeout_err});
        end
        start_frame(4'b1110);
        for (int i = 0; i < 8; i++) begin
            vec_count++;
            if (data !== exp[7-i] || busy !== 1'b1) begin
                err_count++;
                $display("FAIL post_reset_bit%0d: data=%b busy=%b expected data=%b busy=1", i, data, busy, exp[7-i]);
            end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    // Plan item 6: done held high from before start.
    task automatic test_done_early();
        logic [7:0] exp = 8'b1101_0110;
        done = 1'b1;
        start_frame(4'b0110);
        for (int i = 0; i < 8; i++) begin
            vec_count++;
            if (ack !== 1'b0 || data !== exp[7-i]) begin
                err_count++;
                $display("FAIL early_done_bit%0d: ack=%b data=%b expected ack=0 data=%b", i, ack, data, exp[7-i]);
            end
            tick();
        end
        vec_count++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
            err_count++;
            $display("FAIL early_done_wait0: ack=%b busy=%b expected 0 1", ack, busy);
        end
        tick();
        vec_count++;
        if (ack !== 1'b1) begin
            err_count++;
            $display("FAIL early_done_ack: ack=%b expected 1", ack);
        end
        tick();
        vec_count++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            err_count++;
            $display("FAIL early_done_after: ack=%b busy=%b expected 0 0", ack, busy);
        end
        tick();
        vec_count++;
        if (ack !== 1'b0) begin
            err_count++;
            $display("FAIL early_done_single: ack=%b expected 0", ack);
        end
        done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        delay = 4'd0;
        done  = 1'b0;
        test_reset();
        test_frame_and_ack();
        test_start_ignored();
        test_timeout_back_to_back();
        test_done_at_timeout();
        test_reset_mid_frame();
        test_done_early();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
